// File: rtl/mem_alu_core.sv
// Register-file memory plus r1/r2/r3 ALU core, one instruction per 4-cycle
// IDLE/READ/EXEC/WB pass. Define MEM_ALU_SAT_EN for saturating add/sub/mul.
module mem_alu_core #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [4+3*AW-1:0]      instr,
  output logic                   busy,
  output logic                   done,
  output logic                   err_div0,
  output logic                   err_illegal,
  output logic [DW-1:0]          r1,
  output logic [DW-1:0]          r2,
  output logic [DW-1:0]          r3,
  output logic [DW*(2**AW)-1:0]  mem_flat,
  input  logic [AW-1:0]          rd_addr,
  output logic [DW-1:0]          rd_data
);
  localparam int IW    = 4 + 3*AW;
  localparam int DEPTH = 2**AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]                 state;
  logic [IW-1:0]              ir;
  // Packed so word k lands at [k*DW +: DW] of the flat image without remapping.
  logic [DEPTH-1:0][DW-1:0]   mem;

  logic [3:0]      op;
  logic [AW-1:0]   a1, a2, dst;
  logic [2*AW-1:0] imm;
  logic            reserved, div_zero, is_div;

  assign op  = ir[IW-1 -: 4];
  assign a2  = ir[3*AW-1 -: AW];
  assign a1  = ir[2*AW-1 -: AW];
  assign dst = ir[AW-1:0];
  assign imm = ir[3*AW-1:AW];

  assign reserved = (op == 4'h5) || (op == 4'h6) || (op == 4'h7);
  assign is_div   = (op == 4'hE) || (op == 4'hF);
  assign div_zero = (r2 == '0);

  assign instr_ready = (state == S_IDLE);
  assign busy        = !instr_ready;
  assign mem_flat    = mem;
  assign rd_data     = mem[rd_addr];

  // Widened arithmetic keeps the carry/borrow/high product for saturation.
  logic [DW:0]      sum, diff;
  logic [2*DW-1:0]  prod;
  logic [DW-1:0]    add_res, sub_res, mul_res, quo, rem, result;

  assign sum  = {1'b0, r1} + {1'b0, r2};
  assign diff = {1'b0, r1} - {1'b0, r2};
  assign prod = {{DW{1'b0}}, r1} * {{DW{1'b0}}, r2};
  assign quo  = div_zero ? {DW{1'b1}} : r1 / r2;
  assign rem  = div_zero ? r1 : r1 % r2;

`ifdef MEM_ALU_SAT_EN
  assign add_res = sum[DW]            ? {DW{1'b1}} : sum[DW-1:0];
  assign sub_res = diff[DW]           ? {DW{1'b0}} : diff[DW-1:0];
  assign mul_res = |prod[2*DW-1:DW]   ? {DW{1'b1}} : prod[DW-1:0];
`else
  assign add_res = sum[DW-1:0];
  assign sub_res = diff[DW-1:0];
  assign mul_res = prod[DW-1:0];
`endif

  always_comb begin
    result = '0;
    case (op)
      4'h0:    result = DW'(imm);
      4'h1:    result = DW'(r1 == r2);
      4'h2:    result = DW'(r1 <  r2);
      4'h3:    result = DW'(r1 <= r2);
      4'h4:    result = r1 | r2;
      4'h8:    result = r1 & r2;
      4'h9:    result = r1 ^ r2;
      4'hA:    result = ~r1;
      4'hB:    result = add_res;
      4'hC:    result = sub_res;
      4'hD:    result = mul_res;
      4'hE:    result = quo;
      4'hF:    result = rem;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir          <= '0;
      mem         <= '0;
      r1          <= '0;
      r2          <= '0;
      r3          <= '0;
      done        <= 1'b0;
      err_div0    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) begin
          ir    <= instr;
          state <= S_READ;
        end
        S_READ: begin
          r1    <= mem[a1];
          r2    <= mem[a2];
          state <= S_EXEC;
        end
        S_EXEC: begin
          r3 <= result;
          if (is_div && div_zero) err_div0 <= 1'b1;
          if (reserved)           err_illegal <= 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          if (!reserved) mem[dst] <= r3;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_alu_core.sv
// Directed bench for mem_alu_core: reference model feeds a scoreboard that is
// drained on every done pulse; MEM_ALU_SAT_EN selects the saturating model.
module tb_mem_alu_core;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int IW = 4 + 3*AW;
  localparam int N  = 2**AW;
  localparam int MAXV = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid = 1'b0;
  logic [IW-1:0] instr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic instr_ready, busy, done, err_div0, err_illegal;
  logic [DW-1:0] r1, r2, r3, rd_data;
  logic [DW*N-1:0] mem_flat;

  mem_alu_core #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .busy(busy), .done(done), .err_div0(err_div0),
    .err_illegal(err_illegal), .r1(r1), .r2(r2), .r3(r3), .mem_flat(mem_flat),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] dst;
    logic [DW-1:0] mem_val;
    logic [DW-1:0] r1e, r2e, r3e;
    logic          div0, ill;
  } exp_t;

  exp_t sb[$];
  logic [DW-1:0] mm [N];
  logic m_div0 = 1'b0, m_ill = 1'b0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] word(input int k);
    return mem_flat[k*DW +: DW];
  endfunction

  function automatic logic [DW:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [2*AW-1:0] imm);
    int s;
    logic wr;
    logic [DW-1:0] r;
    wr = 1'b1;
    r  = '0;
    s  = 0;
    case (op)
      4'h0: r = DW'(imm);
      4'h1: r = (a == b) ? 1 : 0;
      4'h2: r = (a <  b) ? 1 : 0;
      4'h3: r = (a <= b) ? 1 : 0;
      4'h4: r = a | b;
      4'h8: r = a & b;
      4'h9: r = a ^ b;
      4'hA: r = ~a;
      4'hB: begin
        s = int'(a) + int'(b);
`ifdef MEM_ALU_SAT_EN
        if (s > MAXV) s = MAXV;
`endif
        r = DW'(s);
      end
      4'hC: begin
        s = int'(a) - int'(b);
`ifdef MEM_ALU_SAT_EN
        if (s < 0) s = 0;
`endif
        r = DW'(s);
      end
      4'hD: begin
        s = int'(a) * int'(b);
`ifdef MEM_ALU_SAT_EN
        if (s > MAXV) s = MAXV;
`endif
        r = DW'(s);
      end
      4'hE: r = (b == 0) ? {DW{1'b1}} : a / b;
      4'hF: r = (b == 0) ? a : a % b;
      default: begin wr = 1'b0; r = '0; end
    endcase
    return {wr, r};
  endfunction

  task automatic push(input logic [IW-1:0] ins);
    logic [3:0] op;
    logic [AW-1:0] a1, a2, dst;
    logic [DW:0] res;
    logic [DW-1:0] va, vb;
    op  = ins[IW-1 -: 4];
    a2  = ins[3*AW-1 -: AW];
    a1  = ins[2*AW-1 -: AW];
    dst = ins[AW-1:0];
    va  = mm[a1];
    vb  = mm[a2];
    res = model(op, va, vb, ins[3*AW-1:AW]);
    if ((op == 4'hE || op == 4'hF) && vb == 0) m_div0 = 1'b1;
    if (op == 4'h5 || op == 4'h6 || op == 4'h7) m_ill = 1'b1;
    if (res[DW]) mm[dst] = res[DW-1:0];
    sb.push_back('{dst, mm[dst], va, vb, res[DW-1:0], m_div0, m_ill});
  endtask

  // Scoreboard drain: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wb_mem", word(int'(e.dst)), e.mem_val);
        chk("wb_r1", r1, e.r1e);
        chk("wb_r2", r2, e.r2e);
        chk("wb_r3", r3, e.r3e);
        chk("wb_div0", err_div0, e.div0);
        chk("wb_illegal", err_illegal, e.ill);
      end
    end
  end

  task automatic issue(input logic [IW-1:0] ins);
    int cnt;
    @(negedge clk);
    chk("ready_before", instr_ready, 1'b1);
    push(ins);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_phase", {instr_ready, busy, done}, 3'b010);
    end
    @(negedge clk);
    cnt = 0;
    while (!done && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("done_latency", cnt, 0);
    @(negedge clk);
    chk("done_single", done, 1'b0);
  endtask

  task automatic reset_model();
    for (int k = 0; k < N; k++) mm[k] = '0;
    m_div0 = 1'b0;
    m_ill  = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [IW-1:0] q [2];
    int acc [2];
    logic dn [2];
    int n;
    logic [3:0] ops [9];

    reset_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {instr_ready, busy, done}, 3'b100);
    chk("rst_flags", {err_div0, err_illegal}, 2'b00);
    chk("rst_regs", {r1, r2, r3}, 24'h0);
    chk("rst_mem", 64'(|mem_flat), 64'd0);

    // Immediate load and debug read port
    issue(16'h02A3);
    rd_addr = 4'd3;
    #1;
    chk("imm_rd_data", rd_data, 8'h2A);
    chk("imm_mem3", word(3), 8'h2A);

    // Add with overflow
    issue(16'h0C81);
    issue(16'h0642);
    issue(16'hB214);
    chk("add_r1", r1, 8'hC8);
    chk("add_r2", r2, 8'h64);
`ifdef MEM_ALU_SAT_EN
    chk("add_mem4", word(4), 8'hFF);
`else
    chk("add_mem4", word(4), 8'h2C);
`endif

    // Divide / modulo by zero, sticky flag
    issue(16'h0091);
    issue(16'h0002);
    issue(16'hE215);
    chk("div0_mem5", word(5), 8'hFF);
    chk("div0_flag", err_div0, 1'b1);
    issue(16'hF216);
    chk("mod0_mem6", word(6), 8'h09);
    chk("div0_sticky", err_div0, 1'b1);

    // Reserved opcode: no write, r3 cleared
    issue(16'h0777);
    issue(16'h5217);
    chk("rsv_mem7", word(7), 8'h77);
    chk("rsv_r3", r3, 8'h00);
    chk("rsv_flag", err_illegal, 1'b1);

    // Remaining opcodes on a nonzero pair, checked through the scoreboard
    issue(16'h0372);
    ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD};
    for (int i = 0; i < 9; i++) issue({ops[i], 4'd2, 4'd1, 4'(8 + (i % 8))});
    issue(16'hC12A);   // 0x37 - 0x09 and back: borrow path
    issue(16'hC21B);
    issue(16'hB119);   // a1 == a2
    for (int k = 0; k < N; k++) begin
      rd_addr = 4'(k);
      #1;
      chk("rd_sweep", rd_data, mm[k]);
    end

    // Backpressure: valid held high across two instructions
    q[0] = 16'h9213;
    q[1] = 16'hB33B;   // reads the previous result
    n = 0;
    acc[0] = 0; acc[1] = 0;
    dn[0] = 1'b0; dn[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (n < 2 && instr_ready) begin
        acc[n] = k;
        dn[n] = done;
        instr = q[n];
        instr_valid = 1'b1;
        push(q[n]);
        n++;
      end else if (n == 2 && !instr_ready) begin
        instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk("bp_accepts", n, 2);
    chk("bp_spacing", acc[1] - acc[0], 4);
    chk("bp_done_before", dn[1], 1'b1);
    chk("bp_memB", word(11), mm[11]);
    chk("bp_idle", {instr_ready, busy}, 2'b10);

    // Reset during EXEC of an add
    @(negedge clk);
    instr = 16'hB214;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_no_done", done, 1'b0);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    chk("rstmid_ready", {instr_ready, busy, done}, 3'b100);
    chk("rstmid_mem", 64'(|mem_flat), 64'd0);
    chk("rstmid_flags", {err_div0, err_illegal}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_quiet", {done, word(4)}, 9'h0);
    end

    issue(16'h0155);
    chk("post_rst_mem5", word(5), 8'h15);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
